// File: rtl/btn_debounce.sv
// Multi-channel button synchroniser and debouncer: clean level plus rise/fall pulses.
// Optional auto-repeat of btn_rise while held: define BTN_DEBOUNCE_AUTO_REPEAT_EN.
module btn_debounce #(
  parameter int NUM_BTN    = 4,
  parameter int DB_CYCLES  = 1000000,
  parameter int CNT_W      = 20,
  parameter int REPEAT_DLY = 50000000,
  parameter int REPEAT_PER = 20000000,
  parameter int RPT_W      = 27
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_lvl,
  output logic [NUM_BTN-1:0] btn_rise,
  output logic [NUM_BTN-1:0] btn_fall
);

  typedef enum logic [1:0] {
    S_LO,
    S_LO2HI,
    S_HI,
    S_HI2LO
  } state_t;

  localparam logic [CNT_W-1:0] CNT_END =
    CNT_W'(DB_CYCLES - 1);

  state_t             state [NUM_BTN];
  logic [CNT_W-1:0]   cnt   [NUM_BTN];
  logic [NUM_BTN-1:0] s1;
  logic [NUM_BTN-1:0] s2;

`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
  localparam logic [RPT_W-1:0] DLY_END =
    RPT_W'(REPEAT_DLY - 1);
  localparam logic [RPT_W-1:0] PER_END =
    RPT_W'(REPEAT_PER - 1);

  logic [RPT_W-1:0]   rpt [NUM_BTN];
  logic [NUM_BTN-1:0] rpt_run;
`else
  // repeat parameters have no effect when auto-repeat is compiled out
  if (RPT_W < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1)
  begin : g_rpt_ignored
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      btn_lvl  <= '0;
      btn_rise <= '0;
      btn_fall <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i] <= S_LO;
        cnt[i]   <= '0;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
        rpt[i]     <= '0;
        rpt_run[i] <= 1'b0;
`endif
      end
    end else begin
      s1       <= btn_in;
      s2       <= s1;
      btn_rise <= '0;
      btn_fall <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        unique case (state[i])
          S_LO: begin
            if (s2[i]) begin
              state[i] <= S_LO2HI;
              cnt[i]   <= '0;
            end
          end
          S_LO2HI: begin
            if (!s2[i]) begin
              state[i] <= S_LO;
            end else if (cnt[i] == CNT_END) begin
              state[i]    <= S_HI;
              btn_lvl[i]  <= 1'b1;
              btn_rise[i] <= 1'b1;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
              rpt[i]     <= '0;
              rpt_run[i] <= 1'b0;
`endif
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          S_HI: begin
            if (!s2[i]) begin
              state[i] <= S_HI2LO;
              cnt[i]   <= '0;
            end
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
            // first repeat after DLY, then every PER
            else if (rpt[i] ==
                     (rpt_run[i] ? PER_END : DLY_END)) begin
              btn_rise[i] <= 1'b1;
              rpt[i]      <= '0;
              rpt_run[i]  <= 1'b1;
            end else begin
              rpt[i] <= rpt[i] + 1'b1;
            end
`endif
          end
          S_HI2LO: begin
            if (s2[i]) begin
              state[i] <= S_HI;
            end else if (cnt[i] == CNT_END) begin
              state[i]    <= S_LO;
              btn_lvl[i]  <= 1'b0;
              btn_fall[i] <= 1'b1;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
              rpt[i]     <= '0;
              rpt_run[i] <= 1'b0;
`endif
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          default: state[i] <= S_LO;
        endcase
      end
    end
  end

endmodule
